// File: rtl/dbus_initiator_if.sv
// data_bus: req/gnt address phase, rvalid/rdata response phase.
// master drives req/we/addr/wdata; slave drives gnt/rvalid/rdata.
interface data_bus;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dbus_initiator.sv
// Single-outstanding data_bus initiator: cmd valid/ready -> one bus txn -> rsp.
// Ports: cmd_* in, rsp_* out, dbus master; misalign and timeout give rsp_err.
module dbus_initiator #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  data_bus.master     dbus
);

  localparam int CW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CMAX =
    CW'((TIMEOUT > 0) ? TIMEOUT : 0);
  localparam logic [CW-1:0] CLAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RSP
  } state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rv_q, rv_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic        expire;

  assign cmd_ready  = (state_q == S_IDLE);
  assign rsp_valid  = rv_q;
  assign rsp_err    = err_q;
  assign rsp_rdata  = rdata_q;
  assign dbus.req   = req_q;
  assign dbus.we    = we_q;
  assign dbus.addr  = addr_q;
  assign dbus.wdata = wdata_q;

  // Saturating count; expiry is checked on the last allowed cycle so
  // the bus is held exactly TIMEOUT cycles in REQ or WAIT.
  assign cnt_inc = (cnt_q == CMAX) ? cnt_q : cnt_q + CW'(1);
  assign expire  = (TIMEOUT > 0) && (cnt_q == CLAST);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rv_d    = rv_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          we_d    = cmd_we;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          cnt_d   = '0;
          if (cmd_addr[1:0] != 2'b00) begin
            state_d = S_RSP;
            rv_d    = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = S_REQ;
            req_d   = 1'b1;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_inc;
        if (dbus.gnt) begin
          state_d = S_WAIT;
          req_d   = 1'b0;
          cnt_d   = '0;
        end else if (expire) begin
          state_d = S_RSP;
          req_d   = 1'b0;
          rv_d    = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (dbus.rvalid) begin
          state_d = S_RSP;
          rv_d    = 1'b1;
          err_d   = 1'b0;
          rdata_d = we_q ? 32'h0 : dbus.rdata;
        end else if (expire) begin
          state_d = S_RSP;
          rv_d    = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          rv_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  a_req_aligned: assert property (
    @(posedge clk) disable iff (!rst_n)
    req_q |-> (addr_q[1:0] == 2'b00));

  a_rsp_hold: assert property (
    @(posedge clk) disable iff (!rst_n)
    (rv_q && !rsp_ready) |=> rv_q);

endmodule

// File: tb/tb_dbus_initiator.sv
// Directed bench for dbus_initiator with a small scripted data_bus slave.
// Auto mode: gnt=req and rvalid one cycle after gnt; manual mode: driven.
module tb_dbus_initiator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_err;
  logic [31:0] rsp_rdata;

  logic        auto_m = 1'b0;
  logic        gnt_m = 1'b0;
  logic        rv_m = 1'b0;
  logic        rv_auto = 1'b0;
  logic [31:0] rdata_v = '0;

  int n_cmp = 0;
  int n_bad = 0;

  data_bus bus ();

  assign bus.gnt    = auto_m ? bus.req : gnt_m;
  assign bus.rvalid = auto_m ? rv_auto : rv_m;
  assign bus.rdata  = rdata_v;

  always @(posedge clk) rv_auto <= bus.req & bus.gnt;

  always #5 clk = ~clk;

  dbus_initiator #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .dbus      (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] a,
                       input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic handshake;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || bus.req !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctl: rdy=%b rv=%b req=%b want 1 0 0",
               cmd_ready, rsp_valid, bus.req);
    end
    n_cmp++;
    if (bus.addr !== 32'h0 || bus.wdata !== 32'h0 || bus.we !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_bus: addr=%h wd=%h we=%b want 0",
               bus.addr, bus.wdata, bus.we);
    end
    n_cmp++;
    if (rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_rsp: err=%b rd=%h want 0 0", rsp_err, rsp_rdata);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read_zero_wait;
    auto_m  = 1'b1;
    rdata_v = 32'h1234_5678;
    issue(1'b0, 32'h4, 32'h0);
    n_cmp++;
    if (bus.req !== 1'b1 || bus.addr !== 32'h4 || cmd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_req: req=%b addr=%h rdy=%b want 1 4 0",
               bus.req, bus.addr, cmd_ready);
    end
    tick();
    n_cmp++;
    if (bus.req !== 1'b0 || rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_req_len: req=%b rv=%b want 0 0", bus.req, rsp_valid);
    end
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678 ||
        rsp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_rsp: rv=%b rd=%h err=%b want 1 12345678 0",
               rsp_valid, rsp_rdata, rsp_err);
    end
    handshake();
    n_cmp++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rd_done: rv=%b rdy=%b want 0 1", rsp_valid, cmd_ready);
    end
    auto_m = 1'b0;
  endtask

  task automatic test_write_delayed_gnt;
    gnt_m = 1'b0;
    issue(1'b1, 32'h8, 32'hA5A5_0F0F);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) gnt_m = 1'b1;
      n_cmp++;
      if (bus.req !== 1'b1 || bus.addr !== 32'h8 ||
          bus.wdata !== 32'hA5A5_0F0F || bus.we !== 1'b1) begin
        n_bad++;
        $display("FAIL wr_hold[%0d]: req=%b addr=%h wd=%h we=%b",
                 i, bus.req, bus.addr, bus.wdata, bus.we);
      end
      tick();
    end
    gnt_m = 1'b0;
    n_cmp++;
    if (bus.req !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_req_drop: req=%b want 0", bus.req);
    end
    rv_m    = 1'b1;
    rdata_v = 32'hDEAD_BEEF;
    tick();
    rv_m = 1'b0;
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_rsp: rv=%b rd=%h err=%b want 1 0 0",
               rsp_valid, rsp_rdata, rsp_err);
    end
    handshake();
  endtask

  task automatic test_misaligned;
    int reqs;
    reqs = 0;
    issue(1'b0, 32'h6, 32'h0);
    if (bus.req) reqs++;
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL mis_rsp: rv=%b err=%b rd=%h want 1 1 0",
               rsp_valid, rsp_err, rsp_rdata);
    end
    handshake();
    if (bus.req) reqs++;
    n_cmp++;
    if (reqs !== 0) begin
      n_bad++;
      $display("FAIL mis_noreq: req cycles=%0d want 0", reqs);
    end
  endtask

  task automatic test_timeout_req;
    int reqn;
    bit seen;
    reqn = 0;
    seen = 0;
    gnt_m = 1'b0;
    issue(1'b0, 32'h10, 32'h0);
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.req) reqn++;
      if (rsp_valid) seen = 1;
      else tick();
    end
    n_cmp++;
    if (!seen || reqn !== 16 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL to_req: seen=%b reqn=%0d err=%b rd=%h want 1 16 1 0",
               seen, reqn, rsp_err, rsp_rdata);
    end
    handshake();
  endtask

  task automatic test_timeout_wait;
    int reqn;
    int waitn;
    bit seen;
    reqn  = 0;
    waitn = 0;
    seen  = 0;
    gnt_m = 1'b1;
    issue(1'b0, 32'h14, 32'h0);
    for (int i = 0; i < 40 && !seen; i++) begin
      if (rsp_valid) seen = 1;
      else begin
        if (bus.req) reqn++;
        else waitn++;
        tick();
      end
    end
    gnt_m = 1'b0;
    n_cmp++;
    if (!seen || reqn !== 1 || waitn !== 16 || rsp_err !== 1'b1 ||
        rsp_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL to_wait: seen=%b reqn=%0d waitn=%0d err=%b want 1 1 16 1",
               seen, reqn, waitn, rsp_err);
    end
    handshake();
  endtask

  task automatic test_backpressure;
    auto_m  = 1'b1;
    rdata_v = 32'h0BAD_F00D;
    issue(1'b0, 32'hC, 32'h0);
    tick();
    tick();
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_addr  = 32'h18;
    rdata_v   = 32'h600D_CAFE;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0BAD_F00D ||
          cmd_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: rv=%b rd=%h rdy=%b want 1 0badf00d 0",
                 i, rsp_valid, rsp_rdata, cmd_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_cmp++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || bus.req !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_release: rv=%b rdy=%b req=%b want 0 1 0",
               rsp_valid, cmd_ready, bus.req);
    end
    tick();
    cmd_valid = 1'b0;
    n_cmp++;
    if (bus.req !== 1'b1 || bus.addr !== 32'h18) begin
      n_bad++;
      $display("FAIL bp_next: req=%b addr=%h want 1 18", bus.req, bus.addr);
    end
    tick();
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h600D_CAFE) begin
      n_bad++;
      $display("FAIL bp_next_rsp: rv=%b rd=%h want 1 600dcafe",
               rsp_valid, rsp_rdata);
    end
    handshake();
    auto_m = 1'b0;
  endtask

  task automatic test_reset_in_wait;
    int stray;
    stray = 0;
    gnt_m = 1'b1;
    issue(1'b0, 32'h1C, 32'h0);
    tick();
    gnt_m = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.req !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid: req=%b rv=%b rdy=%b want 0 0 1",
               bus.req, rsp_valid, cmd_ready);
    end
    tick();
    rst_n = 1'b1;
    rv_m  = 1'b1;
    tick();
    rv_m = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid) stray++;
      tick();
    end
    n_cmp++;
    if (stray !== 0) begin
      n_bad++;
      $display("FAIL rst_no_rsp: rsp cycles=%0d want 0", stray);
    end
    auto_m  = 1'b1;
    rdata_v = 32'hCAFE_0020;
    issue(1'b0, 32'h20, 32'h0);
    tick();
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_0020 ||
        rsp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_after_rd: rv=%b rd=%h err=%b want 1 cafe0020 0",
               rsp_valid, rsp_rdata, rsp_err);
    end
    handshake();
    auto_m = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_delayed_gnt();
    test_misaligned();
    test_timeout_req();
    test_timeout_wait();
    test_backpressure();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
